mult_sched_rr: RTL and testbench
================================

// Module: mult_sched_rr
// PURPOSE
//  Round-robin scheduler sharing one sequential 10x10 unsigned multiplier among NREQ requesters.
//  Takes operand pairs over per-requester valid/ready ports, issues a one-cycle start to the
//  multiplier, waits for done, returns the product tagged with the requester ID.
//  Sits between client blocks and the multiplier; the only driver of the multiplier's St/operand inputs.
// PARAMETERS
//  NREQ    4   number of requesters (2..8)
//  W       10  operand width; product is 2*W
//  TO_CYC  64  watchdog limit in cycles spent in WAIT (used only with MULT_SCHED_TIMEOUT_EN)
// PORTS
//  clk        in   1            system clock, rising edge
//  rst_n      in   1            synchronous reset, active-low
//  req_valid  in   NREQ         requester i has an operand pair pending
//  req_ready  out  NREQ         one-hot grant pulse; accepts requester i's operands this cycle
//  req_mplier in   NREQ*W       packed multipliers, requester i at [i*W +: W]
//  req_mcand  in   NREQ*W       packed multiplicands, same packing
//  rsp_valid  out  1            result available
//  rsp_ready  in   1            consumer accepts result
//  rsp_id     out  $clog2(NREQ) index of requester that owns the result
//  rsp_prod   out  2*W          product
//  rsp_err    out  1            result aborted by watchdog (tied 0 without macro)
//  m_st       out  1            multiplier start, one-cycle pulse
//  m_mplier   out  W            multiplier operand, held stable from ISSUE to end of WAIT
//  m_mcand    out  W            multiplicand operand, held stable from ISSUE to end of WAIT
//  m_prod     in   2*W          multiplier product
//  m_done     in   1            multiplier done (level or pulse; first high cycle in WAIT counts)
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge): state=IDLE, rr pointer=0 (req0 highest priority); all outputs 0.
//  FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//   IDLE : if any req_valid: grant the first valid index at or after the pointer (wrapping),
//          assert req_ready[g] for that cycle only, latch operands and g, pointer <= g+1 mod NREQ.
//          No valid -> stay; req_ready all 0.
//   ISSUE: m_st=1 for exactly this cycle; operands already driven. -> WAIT.
//   WAIT : m_st=0. On first cycle m_done=1: latch m_prod into rsp_prod. -> RESP.
//          m_done seen in any other state is ignored.
//   RESP : rsp_valid=1; rsp_id/rsp_prod/rsp_err stable until rsp_ready=1; then -> IDLE next cycle.
//  No new grant while a job is outstanding (at most one in flight); req_ready is 0 outside IDLE.
//  Latency: grant at cycle T, m_st at T+1, rsp_valid at D+1 where D = cycle m_done first seen in WAIT.
//  Requester holding req_valid without grant must keep operands stable; grant is not revoked.
//  Zero operands are issued normally (no bypass).
//  Reset mid-operation: job dropped, no response, FSM to IDLE, m_st low the next cycle.
//  Simultaneous rsp_ready and new req_valid in RESP: response retires; grant happens next cycle in IDLE.
// CONFIGURATION
//  MULT_SCHED_TIMEOUT_EN defined: cycle counter cleared on entering WAIT; if it reaches TO_CYC
//   without m_done -> RESP with rsp_err=1, rsp_prod=0. m_done arriving on the same cycle as
//   expiry wins (normal result, rsp_err=0).
//  Undefined: no counter; WAIT holds indefinitely; rsp_err constant 0.
// STRUCTURE
//  Package mult_sched_pkg: state enum (IDLE, ISSUE, WAIT, RESP), default W, NREQ, TO_CYC,
//   product width constant 2*W.
//  Sub-module rr_arbiter: NREQ-bit request vector + pointer -> one-hot grant + encoded index;
//   purely combinational, pointer register kept in mult_sched_rr.
// TESTING (bench pairs the block with the real multiplier plus a stub that can suppress done)
//  1. req0 only, 1023 x 1023 -> one req_ready[0] pulse, one m_st pulse, rsp_prod=20'hFF801 (1046529), rsp_id=0.
//  2. req0..3 all valid continuously, distinct operands -> grants 0,1,2,3,0 in order; each product correct.
//  3. req2 result with rsp_ready=0 for 10 cycles -> rsp_valid/rsp_prod held; req1 pending but not granted until retire.
//  4. rst_n=0 while in WAIT -> all outputs 0 next cycle, no response; req3 then granted first, pointer 0 (3 valid only).
//  5. 0 x 513 and 1 x 1023 -> products 0 and 1023, normal latency.
//  6. TIMEOUT_EN, stub never asserts done -> rsp_err=1, rsp_prod=0 after TO_CYC=64 WAIT cycles; without macro no response.

Source files
------------

// File: rtl/mult_sched_pkg.sv
// Shared types and defaults for the round-robin multiplier scheduler.
// The optional WAIT watchdog is enabled by defining MULT_SCHED_TIMEOUT_EN.
package mult_sched_pkg;

    localparam int NREQ_DEF   = 4;
    localparam int W_DEF      = 10;
    localparam int TO_CYC_DEF = 64;
    localparam int PW_DEF     = 2 * W_DEF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } schedState_t;

    // Increment modulo n, used to advance the round-robin pointer past the winner.
    function automatic int wrapInc(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
// Produces a one-hot grant plus its encoded index; the pointer register lives in the caller.
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] grantIdx,
    output logic                    grantAny
);

    localparam int IW = $clog2(NREQ);

    // candIdx[k] is the requester examined k-th, i.e. (ptr + k) mod NREQ.
    logic [IW-1:0] candIdx [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
        logic [IW:0] sumW;
        assign sumW        = {1'b0, ptr} + (IW+1)'(gi);
        assign candIdx[gi] = (sumW >= (IW+1)'(NREQ)) ? IW'(sumW - (IW+1)'(NREQ)) : IW'(sumW);
    end

    always_comb begin
        grant    = '0;
        grantIdx = '0;
        grantAny = 1'b0;
        // Scan from the far end so the candidate nearest the pointer is written last.
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[candIdx[k]]) begin
                grantIdx = candIdx[k];
                grantAny = 1'b1;
            end
        end
        if (grantAny) begin
            grant[grantIdx] = 1'b1;
        end
    end

endmodule

// File: rtl/mult_sched_rr.sv
// Round-robin scheduler sharing one sequential multiplier among NREQ requesters, one job in flight.
// Define MULT_SCHED_TIMEOUT_EN to abort a WAIT lasting TO_CYC cycles with rsp_err=1.
module mult_sched_rr
    import mult_sched_pkg::*;
#(
    parameter int NREQ   = NREQ_DEF,
    parameter int W      = W_DEF,
    parameter int TO_CYC = TO_CYC_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*W-1:0]       req_mplier,
    input  logic [NREQ*W-1:0]       req_mcand,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [2*W-1:0]          rsp_prod,
    output logic                    rsp_err,
    output logic                    m_st,
    output logic [W-1:0]            m_mplier,
    output logic [W-1:0]            m_mcand,
    input  logic [2*W-1:0]          m_prod,
    input  logic                    m_done
);

    localparam int IW = $clog2(NREQ);
    localparam int PW = 2 * W;

    if (NREQ < 2 || NREQ > 8) begin : g_badNreq
        $error("mult_sched_rr: NREQ must be within 2..8");
    end
    if (TO_CYC < 1) begin : g_badTimeout
        $error("mult_sched_rr: TO_CYC must be at least 1");
    end

    schedState_t   stateReg;
    schedState_t   stateNext;
    logic [IW-1:0] ptrReg;
    logic [IW-1:0] idReg;
    logic [W-1:0]  mplierReg;
    logic [W-1:0]  mcandReg;
    logic [PW-1:0] prodReg;

    logic [NREQ-1:0] grant;
    logic [IW-1:0]   grantIdx;
    logic            grantAny;
    logic            doneAccept;
    logic            timeoutHit;

    rr_arbiter #(.NREQ(NREQ)) uArb (
        .req      (req_valid),
        .ptr      (ptrReg),
        .grant    (grant),
        .grantIdx (grantIdx),
        .grantAny (grantAny)
    );

    assign doneAccept = (stateReg == WAIT) && m_done;

`ifdef MULT_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(TO_CYC + 1);

    logic [CW-1:0] waitCntReg;
    logic          errReg;

    // A done arriving on the expiry cycle takes precedence over the abort.
    assign timeoutHit = (stateReg == WAIT) && !m_done && (waitCntReg == CW'(TO_CYC - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            waitCntReg <= '0;
            errReg     <= 1'b0;
        end else begin
            if (stateReg == ISSUE) begin
                waitCntReg <= '0;
            end else if (stateReg == WAIT) begin
                waitCntReg <= waitCntReg + 1'b1;
            end
            if (doneAccept) begin
                errReg <= 1'b0;
            end else if (timeoutHit) begin
                errReg <= 1'b1;
            end
        end
    end

    assign rsp_err = errReg;
`else
    assign timeoutHit = 1'b0;
    assign rsp_err    = 1'b0;
`endif

    always_comb begin
        stateNext = stateReg;
        unique case (stateReg)
            IDLE:    if (grantAny) stateNext = ISSUE;
            ISSUE:   stateNext = WAIT;
            WAIT:    if (doneAccept || timeoutHit) stateNext = RESP;
            RESP:    if (rsp_ready) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stateReg  <= IDLE;
            ptrReg    <= '0;
            idReg     <= '0;
            mplierReg <= '0;
            mcandReg  <= '0;
            prodReg   <= '0;
        end else begin
            stateReg <= stateNext;
            if (stateReg == IDLE && grantAny) begin
                ptrReg    <= IW'(wrapInc(int'(grantIdx), NREQ));
                idReg     <= grantIdx;
                mplierReg <= req_mplier[grantIdx*W +: W];
                mcandReg  <= req_mcand[grantIdx*W +: W];
            end
            if (doneAccept) begin
                prodReg <= m_prod;
            end else if (timeoutHit) begin
                prodReg <= '0;
            end
        end
    end

    // Grant is combinational so the requester sees ready in the same cycle it is chosen.
    assign req_ready = (stateReg == IDLE && rst_n) ? grant : '0;
    assign m_st      = (stateReg == ISSUE);
    assign m_mplier  = mplierReg;
    assign m_mcand   = mcandReg;
    assign rsp_valid = (stateReg == RESP);
    assign rsp_id    = idReg;
    assign rsp_prod  = prodReg;

endmodule

// File: tb/tb_mult_sched_rr.sv
// Bench for mult_sched_rr: multiplier stub with programmable latency, transaction-level model, directed tests.
// Test 6 expectations follow MULT_SCHED_TIMEOUT_EN.
module tb_mult_sched_rr;

    localparam int NREQ   = 4;
    localparam int W      = 10;
    localparam int TO_CYC = 64;
    localparam int IW     = $clog2(NREQ);
    localparam int PW     = 2 * W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_mplier = '0;
    logic [NREQ*W-1:0] req_mcand = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [IW-1:0]     rsp_id;
    logic [PW-1:0]     rsp_prod;
    logic              rsp_err;
    logic              m_st;
    logic [W-1:0]      m_mplier;
    logic [W-1:0]      m_mcand;
    logic [PW-1:0]     m_prod;
    logic              m_done;

    mult_sched_rr #(.NREQ(NREQ), .W(W), .TO_CYC(TO_CYC)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_mplier(req_mplier), .req_mcand(req_mcand),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_prod(rsp_prod), .rsp_err(rsp_err),
        .m_st(m_st), .m_mplier(m_mplier), .m_mcand(m_mcand),
        .m_prod(m_prod), .m_done(m_done)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Multiplier stub: done goes high stubLat cycles after the start is sampled.
    int           stubLat = 2;
    int           stubCnt = 0;
    logic         stubBusy = 1'b0;
    logic         suppressDone = 1'b0;
    logic         strayDone = 1'b0;
    logic [W-1:0] stubA = '0;
    logic [W-1:0] stubB = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            stubBusy <= 1'b0;
        end else if (m_st) begin
            stubBusy <= 1'b1;
            stubCnt  <= stubLat;
            stubA    <= m_mplier;
            stubB    <= m_mcand;
        end else if (stubBusy) begin
            if (stubCnt == 0) stubBusy <= 1'b0;
            else stubCnt <= stubCnt - 1;
        end
    end

    assign m_done = (stubBusy && stubCnt == 0 && !suppressDone) || strayDone;
    assign m_prod = PW'(stubA) * PW'(stubB);

    // Transaction-level model: one job at a time, round-robin from mPtr, result = a*b.
    logic            checkEn = 1'b0;
    logic            mBusy = 1'b0;
    logic            mResp = 1'b0;
    logic            mZero = 1'b1;
    logic            mErr = 1'b0;
    logic            prevRspValid = 1'b0;
    logic [PW-1:0]   mProd = '0;
    logic [NREQ-1:0] expReady;
    int mPtr = 0, mId = 0, mA = 0, mB = 0, mIssueAt = 0, pick = 0, cand = 0;

    int          grantLog[$];
    int          grantCycLog[$];
    int          stCycLog[$];
    int          rspStartLog[$];
    int          rspIdLog[$];
    int          rspProdLog[$];
    logic        rspErrLog[$];

    always @(negedge clk) begin
        if (checkEn) begin
            pick = -1;
            if (!mBusy && rst_n) begin
                for (int k = 0; k < NREQ; k++) begin
                    cand = (mPtr + k) % NREQ;
                    if (pick < 0 && req_valid[cand]) pick = cand;
                end
            end
            expReady = '0;
            if (pick >= 0) expReady[pick] = 1'b1;

            check("req_ready", 32'(req_ready), 32'(expReady));
            check("m_st", 32'(m_st), 32'(mBusy && !mResp && cyc == mIssueAt));
            check("rsp_valid", 32'(rsp_valid), 32'(mResp));
            if (mResp) begin
                check("rsp_id", 32'(rsp_id), 32'(mId));
                check("rsp_prod", 32'(rsp_prod), 32'(mProd));
                check("rsp_err", 32'(rsp_err), 32'(mErr));
            end
            if (mBusy && !mResp && cyc >= mIssueAt) begin
                check("m_mplier", 32'(m_mplier), 32'(mA));
                check("m_mcand", 32'(m_mcand), 32'(mB));
            end
            if (mZero) begin
                check("zero_outputs", {m_mplier, m_mcand, 8'(rsp_id), 1'b0, rsp_err, m_st, rsp_valid},
                      32'd0);
                check("zero_prod", 32'(rsp_prod), 32'd0);
            end

            if (pick >= 0) begin
                grantLog.push_back(pick);
                grantCycLog.push_back(cyc);
                $display("grant   req%0d a=%0d b=%0d cycle=%0d", pick,
                         req_mplier[pick*W +: W], req_mcand[pick*W +: W], cyc);
            end
            if (m_st) stCycLog.push_back(cyc);
            if (rsp_valid && !prevRspValid) rspStartLog.push_back(cyc);
            prevRspValid = rsp_valid;
            if (rsp_valid && rsp_ready) begin
                rspIdLog.push_back(int'(rsp_id));
                rspProdLog.push_back(int'(rsp_prod));
                rspErrLog.push_back(rsp_err);
                $display("resp    id=%0d prod=%0d err=%0d cycle=%0d", rsp_id, rsp_prod, rsp_err, cyc);
            end

            // Advance the model to what must hold after the coming clock edge.
            mZero = 1'b0;
            if (!rst_n) begin
                mBusy = 1'b0;
                mResp = 1'b0;
                mPtr  = 0;
                mZero = 1'b1;
            end else if (pick >= 0) begin
                mBusy    = 1'b1;
                mId      = pick;
                mA       = int'(req_mplier[pick*W +: W]);
                mB       = int'(req_mcand[pick*W +: W]);
                mIssueAt = cyc + 1;
                mPtr     = (pick + 1) % NREQ;
            end else if (mBusy && !mResp && cyc > mIssueAt) begin
                if (m_done) begin
                    mResp = 1'b1;
                    mProd = PW'(mA * mB);
                    mErr  = 1'b0;
                end
`ifdef MULT_SCHED_TIMEOUT_EN
                else if (cyc - mIssueAt == TO_CYC) begin
                    mResp = 1'b1;
                    mProd = '0;
                    mErr  = 1'b1;
                end
`endif
            end else if (mResp && rsp_ready) begin
                mBusy = 1'b0;
                mResp = 1'b0;
            end
        end
    end

    // Requesters: each keeps a queue of {mplier, mcand}; the head is presented until granted.
    logic [2*W-1:0] reqQ [NREQ][$];

    task automatic applyReqs();
        logic [2*W-1:0] hd;
        for (int i = 0; i < NREQ; i++) begin
            if (reqQ[i].size() > 0) begin
                hd = reqQ[i][0];
                req_valid[i]         = 1'b1;
                req_mplier[i*W +: W] = hd[2*W-1:W];
                req_mcand[i*W +: W]  = hd[W-1:0];
            end else begin
                req_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic push(input int r, input int a, input int b);
        reqQ[r].push_back({W'(a), W'(b)});
    endtask

    task automatic step();
        logic [NREQ-1:0] g;
        @(negedge clk);
        g = req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (g[i] && reqQ[i].size() > 0) void'(reqQ[i].pop_front());
        end
        applyReqs();
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic waitResp(input int budget, input int want);
        for (int i = 0; i < budget && rspIdLog.size() < want; i++) step();
        check("resp_count", 32'(rspIdLog.size()), 32'(want));
    endtask

    int base, gBase, sBase;
    int expG[5] = '{0, 1, 2, 3, 0};
    int expP[5] = '{15, 77, 1024, 1023, 20000};

    initial begin
        @(posedge clk);
        #1;
        checkEn = 1'b1;
        doReset();

        // 1: single requester, full-scale operands.
        base = rspIdLog.size(); gBase = grantLog.size(); sBase = stCycLog.size();
        push(0, 1023, 1023);
        applyReqs();
        waitResp(50, base + 1);
        step();
        check("t1_id", 32'(rspIdLog[base]), 32'd0);
        check("t1_prod", 32'(rspProdLog[base]), 32'h000FF801);
        check("t1_grants", 32'(grantLog.size() - gBase), 32'd1);
        check("t1_starts", 32'(stCycLog.size() - sBase), 32'd1);
        check("t1_st_lat", 32'(stCycLog[sBase] - grantCycLog[gBase]), 32'd1);

        // 2: all requesters busy, rotation 0,1,2,3,0.
        doReset();
        base = rspIdLog.size(); gBase = grantLog.size();
        push(0, 3, 5);    push(0, 100, 200);
        push(1, 7, 11);   push(1, 13, 17);
        push(2, 512, 2);  push(2, 1, 1);
        push(3, 1023, 1); push(3, 0, 0);
        applyReqs();
        waitResp(300, base + 8);
        for (int i = 0; i < 5; i++) begin
            check("t2_grant_order", 32'(grantLog[gBase + i]), 32'(expG[i]));
            check("t2_prod", 32'(rspProdLog[base + i]), 32'(expP[i]));
        end

        // 3: backpressured result held while another requester waits.
        base = rspIdLog.size(); gBase = grantLog.size();
        rsp_ready = 1'b0;
        push(2, 300, 7);
        applyReqs();
        for (int i = 0; i < 50 && !rsp_valid; i++) step();
        check("t3_rsp_arrive", 32'(rsp_valid), 32'd1);
        push(1, 9, 9);
        applyReqs();
        for (int i = 0; i < 10; i++) begin
            step();
            check("t3_hold_valid", 32'(rsp_valid), 32'd1);
            check("t3_hold_prod", 32'(rsp_prod), 32'd2100);
            check("t3_no_grant", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        waitResp(50, base + 2);
        check("t3_prod_a", 32'(rspProdLog[base]), 32'd2100);
        check("t3_grant_b", 32'(grantLog[gBase + 1]), 32'd1);
        check("t3_prod_b", 32'(rspProdLog[base + 1]), 32'd81);

        // 4: reset while waiting on the multiplier drops the job.
        stubLat = 30;
        sBase = stCycLog.size();
        push(1, 50, 60);
        applyReqs();
        for (int i = 0; i < 20 && stCycLog.size() == sBase; i++) step();
        step();
        step();
        base = rspIdLog.size();
        rst_n = 1'b0;
        step();
        check("t4_rst_valid", 32'(rsp_valid), 32'd0);
        check("t4_rst_st", 32'(m_st), 32'd0);
        check("t4_rst_ops", {m_mplier, m_mcand}, 32'd0);
        rst_n = 1'b1;
        stubLat = 2;
        gBase = grantLog.size();
        push(3, 2, 3);
        applyReqs();
        waitResp(50, base + 1);
        check("t4_grant3", 32'(grantLog[gBase]), 32'd3);
        check("t4_id", 32'(rspIdLog[base]), 32'd3);
        check("t4_prod", 32'(rspProdLog[base]), 32'd6);
        push(0, 4, 4);
        push(1, 5, 5);
        applyReqs();
        waitResp(80, base + 3);
        check("t4_ptr_wrap", 32'(grantLog[gBase + 1]), 32'd0);

        // 5: zero and unit operands, then a stray done while idle.
        base = rspIdLog.size();
        push(0, 0, 513);
        push(0, 1, 1023);
        applyReqs();
        waitResp(80, base + 2);
        check("t5_zero", 32'(rspProdLog[base]), 32'd0);
        check("t5_unit", 32'(rspProdLog[base + 1]), 32'd1023);
        step();
        strayDone = 1'b1;
        step();
        strayDone = 1'b0;
        repeat (5) step();
        check("t5_stray", 32'(rspIdLog.size()), 32'(base + 2));

        // 6: multiplier never completes.
        base = rspIdLog.size(); sBase = stCycLog.size();
        suppressDone = 1'b1;
        push(0, 5, 5);
        applyReqs();
`ifdef MULT_SCHED_TIMEOUT_EN
        waitResp(150, base + 1);
        check("t6_err", 32'(rspErrLog[base]), 32'd1);
        check("t6_prod", 32'(rspProdLog[base]), 32'd0);
        check("t6_latency", 32'(rspStartLog[rspStartLog.size() - 1] - stCycLog[sBase]), 32'(TO_CYC + 1));
`else
        repeat (200) step();
        check("t6_no_resp", 32'(rspIdLog.size()), 32'(base));
        check("t6_still_waiting", 32'(rsp_valid), 32'd0);
`endif
        suppressDone = 1'b0;
        doReset();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
        $fatal(1, "time limit");
    end

endmodule
